// File: rtl/axi_ram_slave.sv
// AXI4-Lite slave in front of a single-port synchronous word RAM, one transaction at a time, reads before writes.
// Optional build macro AXI_RAM_WSTRB_EN enables per-byte write strobes; without it every write updates the full word.
module axi_ram_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        arvalid_i,
    output logic        aready_o,
    input  logic [31:0] araddr_i,
    output logic        rvalid_o,
    input  logic        rready_i,
    output logic [31:0] rdata_o,
    output logic [1:0]  rresp_o,
    input  logic        awvalid_i,
    output logic        awready_o,
    input  logic [31:0] awaddr_i,
    input  logic        wvalid_i,
    output logic        wready_o,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  wstrb_i,
    output logic        bvalid_o,
    input  logic        bready_i,
    output logic [1:0]  bresp_o
);
    localparam int          IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [32:0] WIN_BYTES = 33'(DEPTH_WORDS) << 2;
    localparam logic [1:0]  RESP_OKAY = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {IDLE, RD_RESP, WR_COLLECT, WR_RESP} state_t;

    state_t             r_state;
    logic [31:0]        r_mem [DEPTH_WORDS];
    logic               r_awCaptured;
    logic               r_wCaptured;
    logic [31:0]        r_awAddr;
    logic [31:0]        r_wData;
    logic [3:0]         r_wStrb;
    logic [31:0]        r_rdata;
    logic [1:0]         r_rresp;
    logic [1:0]         r_bresp;

    logic               w_arHs;
    logic               w_awHs;
    logic               w_wHs;
    logic               w_doWrite;
    logic [31:0]        w_wrAddr;
    logic [31:0]        w_wrData;
    logic [3:0]         w_wrStrb;
    logic [3:0]         w_strbEff;
    logic               w_wrInRange;
    logic               w_rdInRange;
    logic [IDX_W-1:0]   w_wrIdx;
    logic [IDX_W-1:0]   w_rdIdx;

    // Offset is taken modulo 2^32, so addresses below the base wrap high and fail the window test.
    function automatic logic inWindow(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE_ADDR;
        return (addr >= BASE_ADDR) && ({1'b0, off} < WIN_BYTES);
    endfunction

    function automatic logic [IDX_W-1:0] wordIndex(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE_ADDR;
        return IDX_W'(off >> 2);
    endfunction

    assign aready_o  = !rst_i && (r_state == IDLE);
    assign awready_o = !rst_i && ((r_state == IDLE && !arvalid_i) ||
                                  (r_state == WR_COLLECT && !r_awCaptured));
    assign wready_o  = !rst_i && ((r_state == IDLE && !arvalid_i) ||
                                  (r_state == WR_COLLECT && !r_wCaptured));

    assign w_arHs = arvalid_i && aready_o;
    assign w_awHs = awvalid_i && awready_o;
    assign w_wHs  = wvalid_i && wready_o;

    assign w_doWrite = (w_awHs || w_wHs) && (r_awCaptured || w_awHs) && (r_wCaptured || w_wHs);
    assign w_wrAddr  = r_awCaptured ? r_awAddr : awaddr_i;
    assign w_wrData  = r_wCaptured ? r_wData : wdata_i;
    assign w_wrStrb  = r_wCaptured ? r_wStrb : wstrb_i;

`ifdef AXI_RAM_WSTRB_EN
    assign w_strbEff = w_wrStrb;
`else
    assign w_strbEff = w_wrStrb | 4'hF;
`endif

    assign w_wrInRange = inWindow(w_wrAddr);
    assign w_wrIdx     = wordIndex(w_wrAddr);
    assign w_rdInRange = inWindow(araddr_i);
    assign w_rdIdx     = wordIndex(araddr_i);

    // RAM has no reset; writes only happen on a completed, in-window AW+W pair.
    always_ff @(posedge clk_i) begin
        if (!rst_i && w_doWrite && w_wrInRange) begin
            for (int b = 0; b < 4; b++) begin
                if (w_strbEff[b]) begin
                    r_mem[w_wrIdx][8*b +: 8] <= w_wrData[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= IDLE;
            r_awCaptured <= 1'b0;
            r_wCaptured  <= 1'b0;
            r_awAddr     <= '0;
            r_wData      <= '0;
            r_wStrb      <= '0;
            r_rdata      <= '0;
            r_rresp      <= RESP_OKAY;
            r_bresp      <= RESP_OKAY;
        end else begin
            case (r_state)
                IDLE, WR_COLLECT: begin
                    if (w_arHs) begin
                        r_rdata <= w_rdInRange ? r_mem[w_rdIdx] : '0;
                        r_rresp <= w_rdInRange ? RESP_OKAY : RESP_SLVERR;
                        r_state <= RD_RESP;
                    end else if (w_doWrite) begin
                        r_bresp      <= w_wrInRange ? RESP_OKAY : RESP_SLVERR;
                        r_awCaptured <= 1'b0;
                        r_wCaptured  <= 1'b0;
                        r_state      <= WR_RESP;
                    end else if (w_awHs || w_wHs) begin
                        if (w_awHs) begin
                            r_awAddr     <= awaddr_i;
                            r_awCaptured <= 1'b1;
                        end
                        if (w_wHs) begin
                            r_wData     <= wdata_i;
                            r_wStrb     <= wstrb_i;
                            r_wCaptured <= 1'b1;
                        end
                        r_state <= WR_COLLECT;
                    end
                end
                RD_RESP: begin
                    if (rready_i) begin
                        r_state <= IDLE;
                    end
                end
                WR_RESP: begin
                    if (bready_i) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rvalid_o = (r_state == RD_RESP);
    assign bvalid_o = (r_state == WR_RESP);
    assign rdata_o  = r_rdata;
    assign rresp_o  = r_rresp;
    assign bresp_o  = r_bresp;

endmodule

// File: tb/tb_axi_ram_slave.sv
// Directed testbench for axi_ram_slave: handshakes, latency, ordering, strobes, window errors and reset abort.
module tb_axi_ram_slave;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          DEPTH = 16;

`ifdef AXI_RAM_WSTRB_EN
    localparam logic [31:0] STRB_EXP = 32'hFFFF_FFAA;
`else
    localparam logic [31:0] STRB_EXP = 32'h0000_00AA;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        arvalid_i = 1'b0;
    logic        aready_o;
    logic [31:0] araddr_i = '0;
    logic        rvalid_o;
    logic        rready_i = 1'b0;
    logic [31:0] rdata_o;
    logic [1:0]  rresp_o;
    logic        awvalid_i = 1'b0;
    logic        awready_o;
    logic [31:0] awaddr_i = '0;
    logic        wvalid_i = 1'b0;
    logic        wready_o;
    logic [31:0] wdata_i = '0;
    logic [3:0]  wstrb_i = 4'hF;
    logic        bvalid_o;
    logic        bready_i = 1'b0;
    logic [1:0]  bresp_o;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] model [DEPTH];

    axi_ram_slave #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .arvalid_i(arvalid_i), .aready_o(aready_o), .araddr_i(araddr_i),
        .rvalid_o(rvalid_o), .rready_i(rready_i), .rdata_o(rdata_o), .rresp_o(rresp_o),
        .awvalid_i(awvalid_i), .awready_o(awready_o), .awaddr_i(awaddr_i),
        .wvalid_i(wvalid_i), .wready_o(wready_o), .wdata_i(wdata_i), .wstrb_i(wstrb_i),
        .bvalid_o(bvalid_o), .bready_i(bready_i), .bresp_o(bresp_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    function automatic void modelWrite(input int idx, input logic [31:0] data, input logic [3:0] strb);
`ifdef AXI_RAM_WSTRB_EN
        for (int b = 0; b < 4; b++)
            if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
`else
        if (strb == strb) model[idx] = data;
`endif
    endfunction

    // AW and W together; returns response and cycles from handshake edge to bvalid.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                                 output logic [1:0] resp, output int lat);
        bit got = 0;
        awaddr_i = addr; wdata_i = data; wstrb_i = strb;
        awvalid_i = 1'b1; wvalid_i = 1'b1;
        lat = 99; resp = 2'bxx;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk_i);
            if (awready_o && wready_o) begin got = 1; break; end
            @(posedge clk_i); #1;
        end
        if (!got) begin
            checkOutput("awTimeout", 32'd0, 32'd1);
            awvalid_i = 1'b0; wvalid_i = 1'b0;
            return;
        end
        @(posedge clk_i); #1;
        awvalid_i = 1'b0; wvalid_i = 1'b0;
        lat = 1;
        @(negedge clk_i);
        while (!bvalid_o && lat < 20) begin @(negedge clk_i); lat++; end
        resp = bresp_o;
        bready_i = 1'b1;
        @(posedge clk_i); #1;
        bready_i = 1'b0;
    endtask

    task automatic readWord(input logic [31:0] addr, output logic [31:0] data,
                            output logic [1:0] resp, output int lat);
        bit got = 0;
        araddr_i = addr; arvalid_i = 1'b1;
        lat = 99; data = 'x; resp = 2'bxx;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk_i);
            if (aready_o) begin got = 1; break; end
            @(posedge clk_i); #1;
        end
        if (!got) begin
            checkOutput("arTimeout", 32'd0, 32'd1);
            arvalid_i = 1'b0;
            return;
        end
        @(posedge clk_i); #1;
        arvalid_i = 1'b0;
        lat = 1;
        @(negedge clk_i);
        while (!rvalid_o && lat < 20) begin @(negedge clk_i); lat++; end
        data = rdata_o; resp = rresp_o;
        rready_i = 1'b1;
        @(posedge clk_i); #1;
        rready_i = 1'b0;
    endtask

    task automatic scanRam(input string tag);
        logic [31:0] d;
        logic [1:0]  r;
        int          l;
        for (int i = 0; i < DEPTH; i++) begin
            readWord(BASE + 32'(i * 4), d, r, l);
            checkOutput(tag, d, model[i]);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation timeout");
    end

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        int          l;

        @(negedge clk_i);
        checkOutput("readyInReset", {29'd0, aready_o, awready_o, wready_o}, 32'd0);
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        checkOutput("rstValids", {30'd0, rvalid_o, bvalid_o}, 32'd0);
        checkOutput("rstRdata", rdata_o, 32'd0);
        checkOutput("rstResps", {28'd0, rresp_o, bresp_o}, 32'd0);
        checkOutput("idleReadies", {29'd0, aready_o, awready_o, wready_o}, 32'd7);
        @(posedge clk_i); #1;

        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(BASE + 32'(i * 4), 32'hA5A5_0000 + 32'(i * 32'h111), 4'hF, r, l);
            model[i] = 32'hA5A5_0000 + 32'(i * 32'h111);
        end

        applyStimulus(BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, r, l);
        modelWrite(4, 32'hDEAD_BEEF, 4'hF);
        checkOutput("wrBresp", {30'd0, r}, 32'd0);
        checkOutput("wrLatency", 32'(l), 32'd1);
        readWord(BASE + 32'h10, d, r, l);
        checkOutput("rdData", d, 32'hDEAD_BEEF);
        checkOutput("rdRresp", {30'd0, r}, 32'd0);
        checkOutput("rdLatency", 32'(l), 32'd1);

        wdata_i = 32'h1234_5678; wstrb_i = 4'hF; wvalid_i = 1'b1;
        @(negedge clk_i);
        checkOutput("wFirstReady", {31'd0, wready_o}, 32'd1);
        @(posedge clk_i); #1 wvalid_i = 1'b0;
        repeat (2) begin
            @(negedge clk_i);
            checkOutput("collectState", {29'd0, bvalid_o, wready_o, awready_o}, 32'd1);
            @(posedge clk_i); #1;
        end
        awaddr_i = BASE + 32'h4; awvalid_i = 1'b1;
        @(negedge clk_i);
        checkOutput("awLateReady", {31'd0, awready_o}, 32'd1);
        @(posedge clk_i); #1 awvalid_i = 1'b0;
        @(negedge clk_i);
        checkOutput("wFirstBvalid", {31'd0, bvalid_o}, 32'd1);
        checkOutput("wFirstBresp", {30'd0, bresp_o}, 32'd0);
        bready_i = 1'b1;
        @(posedge clk_i); #1 bready_i = 1'b0;
        modelWrite(1, 32'h1234_5678, 4'hF);
        readWord(BASE + 32'h4, d, r, l);
        checkOutput("wFirstReadback", d, 32'h1234_5678);

        applyStimulus(BASE + 32'h20, 32'hFFFF_FFFF, 4'hF, r, l);
        modelWrite(8, 32'hFFFF_FFFF, 4'hF);
        applyStimulus(BASE + 32'h20, 32'h0000_00AA, 4'b0001, r, l);
        modelWrite(8, 32'h0000_00AA, 4'b0001);
        readWord(BASE + 32'h20, d, r, l);
        checkOutput("strbReadback", d, STRB_EXP);

        readWord(BASE + 32'(DEPTH * 4), d, r, l);
        checkOutput("oorRdata", d, 32'd0);
        checkOutput("oorRresp", {30'd0, r}, 32'd2);
        applyStimulus(BASE - 32'd4, 32'hCAFE_F00D, 4'hF, r, l);
        checkOutput("oorBresp", {30'd0, r}, 32'd2);
        scanRam("oorScan");

        araddr_i = BASE + 32'h10; arvalid_i = 1'b1;
        awaddr_i = BASE + 32'h30; wdata_i = 32'h55AA_55AA; wstrb_i = 4'hF;
        awvalid_i = 1'b1; wvalid_i = 1'b1;
        @(negedge clk_i);
        checkOutput("prioReadies", {29'd0, aready_o, awready_o, wready_o}, 32'd4);
        @(posedge clk_i); #1 arvalid_i = 1'b0;
        repeat (5) begin
            @(negedge clk_i);
            checkOutput("holdRvalid", {30'd0, rvalid_o, awready_o}, 32'd2);
            checkOutput("holdRdata", rdata_o, 32'hDEAD_BEEF);
            @(posedge clk_i); #1;
        end
        rready_i = 1'b1;
        @(posedge clk_i); #1 rready_i = 1'b0;
        @(negedge clk_i);
        checkOutput("prioWrReady", {30'd0, awready_o, wready_o}, 32'd3);
        @(posedge clk_i); #1 awvalid_i = 1'b0; wvalid_i = 1'b0;
        @(negedge clk_i);
        checkOutput("prioBvalid", {30'd0, bvalid_o, 1'b0}, 32'd2);
        bready_i = 1'b1;
        @(posedge clk_i); #1 bready_i = 1'b0;
        modelWrite(12, 32'h55AA_55AA, 4'hF);
        readWord(BASE + 32'h30, d, r, l);
        checkOutput("prioReadback", d, 32'h55AA_55AA);

        awaddr_i = BASE + 32'h8; awvalid_i = 1'b1;
        @(negedge clk_i);
        checkOutput("rstAwReady", {31'd0, awready_o}, 32'd1);
        @(posedge clk_i); #1 awvalid_i = 1'b0;
        wdata_i = 32'h0BAD_BAD0; wvalid_i = 1'b1; rst_i = 1'b1;
        @(negedge clk_i);
        checkOutput("rstForcedReady", {30'd0, wready_o, aready_o}, 32'd0);
        @(posedge clk_i); #1 rst_i = 1'b0; wvalid_i = 1'b0;
        @(negedge clk_i);
        checkOutput("postRstValids", {30'd0, rvalid_o, bvalid_o}, 32'd0);
        checkOutput("postRstIdle", {29'd0, aready_o, awready_o, wready_o}, 32'd7);
        @(posedge clk_i); #1;
        readWord(BASE + 32'h8, d, r, l);
        checkOutput("rstKeepsWord", d, model[2]);
        scanRam("finalScan");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
